ekg_lead_sampler: RTL and testbench

Parametrised electrode scan-and-lead engine for the EKG front end. It sits between the SPI controller driving the multi-channel ADC and the anti-alias FIR filter. On a programmable period it sequences one ADC conversion per electrode channel and stores each cleaned sample. It then emits all unipolar-difference leads (electrode k minus reference electrode 0) as one packed signed word with a single-cycle valid.

---
 rtl/ekg_lead_sampler.sv | 152 +++++++++++++++
 tb/tb_ekg_lead_sampler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ekg_lead_sampler.sv
// Electrode scan-and-lead engine: one ADC conversion per electrode per period, then packed leads e[k]-e[0].
// Optional build macro ADC_TIMEOUT_EN adds a bounded WAIT with a sticky timeout flag.
//
// state  | meaning
// IDLE   | waiting for a period tick
// REQ    | one-cycle conversion request for channel ch
// WAIT   | waiting for the ADC answer for channel ch
// ADV    | step ch to the next electrode before the next request
// CALC   | register all leads from the captured samples
module ekg_lead_sampler #(
  parameter int NUM_ELECTRODES = 3,
  parameter int CHANNEL_BASE   = 0,
  parameter int ADC_DATA_WIDTH = 17,
  parameter int SAMPLE_LSB     = 1,
  parameter int SAMPLE_WIDTH   = 10,
  parameter int LEAD_WIDTH     = SAMPLE_WIDTH + 1,
  parameter int READ_PERIOD    = 100_000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  output logic                                         spi_trigger_out,
  output logic [ADC_DATA_WIDTH-1:0]                    spi_data_out,
  input  logic                                         spi_valid_in,
  input  logic [ADC_DATA_WIDTH-1:0]                    spi_data_in,
  output logic [(NUM_ELECTRODES-1)*LEAD_WIDTH-1:0]     leads_out,
  output logic                                         leads_valid_out,
  output logic                                         overrun_out,
  output logic                                         timeout_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ADV  = 3'd3;
  localparam logic [2:0] S_CALC = 3'd4;

  localparam int PCW   = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
  localparam int PAD_W = ADC_DATA_WIDTH - 5;

  logic [2:0]              state;
  logic [2:0]              ch;
  logic [2:0]              chan;
  logic [PCW-1:0]          per_cnt;
  logic                    tick;
  logic                    last_ch;
  logic                    timeout_hit;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic [SAMPLE_WIDTH-1:0] e_q [NUM_ELECTRODES];
  logic                    unused_bits;

  // Down-counting period timer; terminal count 0 is the scan tick.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      per_cnt <= '0;
    end else if (per_cnt == '0) begin
      per_cnt <= PCW'(READ_PERIOD - 1);
    end else begin
      per_cnt <= per_cnt - 1'b1;
    end
  end

  assign tick        = (per_cnt == '0);
  assign last_ch     = (ch == 3'(NUM_ELECTRODES - 1));
  assign chan        = 3'(CHANNEL_BASE) + ch;
  assign sample      = spi_data_in[SAMPLE_LSB +: SAMPLE_WIDTH];
  assign unused_bits = ^spi_data_in;

  assign spi_trigger_out = (state == S_REQ);
  assign spi_data_out    = (state == S_REQ || state == S_WAIT) ?
                           {2'b11, chan, {PAD_W{1'b0}}} : '0;

`ifdef ADC_TIMEOUT_EN
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TCW-1:0] wait_cnt;

  // Loaded while requesting so the first WAIT cycle starts the window.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wait_cnt <= '0;
    end else if (state == S_REQ) begin
      wait_cnt <= TCW'(TIMEOUT_CYCLES - 1);
    end else if (state == S_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign timeout_hit = (state == S_WAIT) && !spi_valid_in && (wait_cnt == '0);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      timeout_out <= 1'b0;
    end else if (timeout_hit) begin
      timeout_out <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign timeout_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= S_IDLE;
      ch              <= '0;
      leads_out       <= '0;
      leads_valid_out <= 1'b0;
      overrun_out     <= 1'b0;
      for (int k = 0; k < NUM_ELECTRODES; k++) e_q[k] <= '0;
    end else begin
      leads_valid_out <= 1'b0;
      if (tick && state != S_IDLE) overrun_out <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            ch    <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (spi_valid_in) begin
            for (int k = 0; k < NUM_ELECTRODES; k++) begin
              if (ch == 3'(k)) e_q[k] <= sample;
            end
            state <= last_ch ? S_CALC : S_ADV;
          end else if (timeout_hit) begin
            ch    <= '0;
            state <= S_IDLE;
          end
        end
        S_ADV: begin
          ch    <= ch + 3'd1;
          state <= S_REQ;
        end
        S_CALC: begin
          // Zero-extended operands keep every difference in range.
          for (int k = 1; k < NUM_ELECTRODES; k++) begin
            leads_out[(k-1)*LEAD_WIDTH +: LEAD_WIDTH] <=
              LEAD_WIDTH'(e_q[k]) - LEAD_WIDTH'(e_q[0]);
          end
          leads_valid_out <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ekg_lead_sampler.sv
// Randomized bench for ekg_lead_sampler: responder plus a cycle/period model of scans, leads and flags.
module tb_ekg_lead_sampler;
  localparam int NE = 3;
  localparam int RP = 64;
  localparam int TO = 16;
  localparam int DW = 17;
  localparam int LW = 11;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 spi_trigger_out;
  logic [DW-1:0]        spi_data_out;
  logic                 spi_valid_in = 1'b0;
  logic [DW-1:0]        spi_data_in = '0;
  logic [(NE-1)*LW-1:0] leads_out;
  logic                 leads_valid_out;
  logic                 overrun_out;
  logic                 timeout_out;

  ekg_lead_sampler #(
    .NUM_ELECTRODES(NE), .CHANNEL_BASE(0), .ADC_DATA_WIDTH(DW),
    .SAMPLE_LSB(1), .SAMPLE_WIDTH(10), .LEAD_WIDTH(LW),
    .READ_PERIOD(RP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .spi_trigger_out(spi_trigger_out), .spi_data_out(spi_data_out),
    .spi_valid_in(spi_valid_in), .spi_data_in(spi_data_in),
    .leads_out(leads_out), .leads_valid_out(leads_valid_out),
    .overrun_out(overrun_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int base, idle_from;
  bit exp_ovr, exp_to;
  int exp_l0, exp_l1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int next_tick(input int c);
    int r;
    r = (c - base) % RP;
    return (r == 0) ? c : c + RP - r;
  endfunction

  function automatic logic [DW-1:0] mkword(input int s);
    logic [DW-1:0] w;
    w = DW'($urandom);
    w[10:1] = 10'(s);
    return w;
  endfunction

  function automatic int lead(input int idx);
    logic [LW-1:0] l;
    l = leads_out[idx*LW +: LW];
    return int'($signed(l));
  endfunction

  task automatic check_leads_held(input string tag);
    chk({tag, "_l0"}, lead(0), exp_l0);
    chk({tag, "_l1"}, lead(1), exp_l1);
  endtask

  task automatic check_reset_state();
    chk("rst_trig", spi_trigger_out, 0);
    chk("rst_data", spi_data_out, 0);
    chk("rst_leads", leads_out, 0);
    chk("rst_lv", leads_valid_out, 0);
    chk("rst_ovr", overrun_out, 0);
    chk("rst_to", timeout_out, 0);
  endtask

  task automatic wait_trig(output int tc);
    tc = -1;
    for (int i = 0; i < 300; i++) begin
      if (spi_trigger_out) begin
        tc = cyc;
        return;
      end
      @(negedge clk_in);
    end
    chk("trig_wait", spi_trigger_out, 1);
  endtask

  // mode: 0 normal, 1 silent on channel 1, 2 reset during channel-1 WAIT, 3 spurious valid in REQ
  task automatic scan(input int dly, input int s0, input int s1, input int s2, input int mode);
    int smp [NE];
    int tc, v, start_tick, exp_tc, e_cyc;
    smp = '{s0, s1, s2};
    start_tick = next_tick(idle_from);
    exp_tc = start_tick + 1;
    e_cyc = -1;
    for (int k = 0; k < NE; k++) begin
      wait_trig(tc);
      if (tc < 0) return;
      chk($sformatf("trig_cyc%0d", k), tc, exp_tc);
      chk($sformatf("cmd%0d", k), spi_data_out, (24 + k) << 12);
      if (mode == 3) begin
        spi_valid_in = 1'b1;
        spi_data_in  = DW'($urandom);
      end
      @(negedge clk_in);
      spi_valid_in = 1'b0;
      chk("trig_width", spi_trigger_out, 0);
      if (k == 1 && mode == 1) begin
        while (cyc < tc + TO) @(negedge clk_in);
        chk("to_early", timeout_out, 0);
        @(negedge clk_in);
        chk("to_set", timeout_out, 1);
        chk("to_no_lv", leads_valid_out, 0);
        exp_to = 1'b1;
        e_cyc = cyc;
        break;
      end
      if (k == 1 && mode == 2) begin
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_reset_state();
        rst_in       = 1'b1;
        spi_valid_in = 1'b1;
        spi_data_in  = DW'($urandom);
        base = cyc;
        idle_from = cyc;
        exp_ovr = 1'b0;
        exp_to = 1'b0;
        exp_l0 = 0;
        exp_l1 = 0;
        @(negedge clk_in);
        spi_valid_in = 1'b0;
        chk("post_rst_lv", leads_valid_out, 0);
        return;
      end
      while (cyc < tc + dly) @(negedge clk_in);
      spi_valid_in = 1'b1;
      spi_data_in  = mkword(smp[k]);
      v = cyc;
      @(negedge clk_in);
      spi_valid_in = 1'b0;
      spi_data_in  = DW'($urandom);
      chk("gap_trig", spi_trigger_out, 0);
      chk("gap_lv", leads_valid_out, 0);
      @(negedge clk_in);
      exp_tc = v + 2;
      if (k == NE - 1) begin
        exp_l0 = s1 - s0;
        exp_l1 = s2 - s0;
        chk("lv", leads_valid_out, 1);
        chk("lead0", lead(0), exp_l0);
        chk("lead1", lead(1), exp_l1);
        e_cyc = cyc;
        @(negedge clk_in);
        chk("lv_width", leads_valid_out, 0);
        check_leads_held("hold");
      end
    end
    if (e_cyc >= 0) begin
      if (next_tick(start_tick + 1) < e_cyc) exp_ovr = 1'b1;
      idle_from = e_cyc;
    end
    chk("overrun", overrun_out, exp_ovr);
    chk("timeout", timeout_out, exp_to);
  endtask

  task automatic spurious_idle();
    for (int i = 0; i < 3; i++) begin
      spi_valid_in = 1'b1;
      spi_data_in  = DW'($urandom);
      @(negedge clk_in);
      spi_valid_in = 1'b0;
      chk("spur_lv", leads_valid_out, 0);
      chk("spur_trig", spi_trigger_out, 0);
      @(negedge clk_in);
    end
    check_leads_held("spur");
  endtask

  function automatic int rs();
    return int'($urandom_range(0, 1023));
  endfunction

  initial begin
    exp_ovr = 1'b0;
    exp_to  = 1'b0;
    exp_l0  = 0;
    exp_l1  = 0;
    repeat (3) @(negedge clk_in);
    check_reset_state();
    base = cyc;
    idle_from = cyc;
    rst_in = 1'b1;

    scan(10, 100, 300, 50, 0);
    scan(12, 1023, 0, 1023, 0);
    for (int i = 0; i < 6; i++) scan(int'($urandom_range(2, 14)), rs(), rs(), rs(), 0);
    scan(30, rs(), rs(), rs(), 0);
    scan(int'($urandom_range(2, 14)), rs(), rs(), rs(), 0);
    spurious_idle();
    scan(8, rs(), rs(), rs(), 3);
    scan(5, rs(), rs(), rs(), 2);
    check_leads_held("rst_hold");
    scan(9, rs(), rs(), rs(), 0);
`ifdef ADC_TIMEOUT_EN
    scan(5, rs(), rs(), rs(), 1);
    check_leads_held("to_hold");
    scan(6, rs(), rs(), rs(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
